// File: rtl/score_display_pkg.sv
// Shared types and active-low 7-segment constants for the score display path.
// Segment bit order is {g,f,e,d,c,b,a}.
package score_display_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low 7-segment pattern; non-decimal codes render as a dash.
module seven_seg_decoder
  import score_display_pkg::*;
(
  input  bcd_t             digit,
  input  logic             blank,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (digit == 4'(i)) seg_c = SEG_DIGIT[i];
    end
    if (blank) seg_c = SEG_BLANK;
  end

endmodule

// File: rtl/score_digit_display_scanner.sv
// Captures strobed score digits into a frame, commits whole frames atomically,
// and scans the committed frame onto a common-anode multi-digit display.
module score_digit_display_scanner
  import score_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned SEL_W       = 1,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [SEL_W-1:0]      STROBE_COUNTER,
  input  bcd_t                  STROBED_SCORE,
  output logic [NUM_DIGITS-1:0] ANODE,
  output logic [SEG_W-1:0]      SEG,
  output logic                  FRAME_VALID
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  bcd_t                  cap_q  [NUM_DIGITS];
  bcd_t                  cap_d  [NUM_DIGITS];
  bcd_t                  disp_q [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] mask_q;
  logic [NUM_DIGITS-1:0] mask_d;
  logic                  commit_c;

  logic [CNT_W-1:0]      cnt_q;
  logic [IDX_W-1:0]      idx_q;
  logic                  wrap_c;

  bcd_t                  digit_c;
  logic                  blank_c;
  logic                  zero_above_c;
  logic [NUM_DIGITS-1:0] anode_c;
  logic [SEG_W-1:0]      dec_seg_c;

  // Out-of-range selects match no slot and so leave cap/mask untouched.
  always_comb begin
    cap_d  = cap_q;
    mask_d = mask_q;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (STROBE_COUNTER == SEL_W'(i)) begin
        cap_d[i]  = STROBED_SCORE;
        mask_d[i] = 1'b1;
      end
    end
    commit_c = &mask_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        cap_q[i]  <= '0;
        disp_q[i] <= '0;
      end
      mask_q      <= '0;
      FRAME_VALID <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      mask_q <= commit_c ? '0 : mask_d;
      if (commit_c) begin
        disp_q      <= cap_d;
        FRAME_VALID <= 1'b1;
      end
    end
  end

  assign wrap_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= wrap_c ? '0 : cnt_q + 1'b1;
      if (wrap_c) idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Walk from the top digit down so zero_above_c covers digits idx..NUM_DIGITS-1.
  always_comb begin
    digit_c      = '0;
    blank_c      = 1'b0;
    zero_above_c = 1'b1;
    anode_c      = '1;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_above_c = zero_above_c && (disp_q[i] == 4'd0);
      if (idx_q == IDX_W'(i)) begin
        digit_c    = disp_q[i];
        blank_c    = BLANK_LZ && (i != 0) && zero_above_c;
        anode_c[i] = 1'b0;
      end
    end
  end

  seven_seg_decoder u_dec (
    .digit (digit_c),
    .blank (blank_c),
    .seg_c (dec_seg_c)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ANODE <= '1;
      SEG   <= SEG_BLANK;
    end else begin
      ANODE <= FRAME_VALID ? anode_c : '1;
      SEG   <= FRAME_VALID ? dec_seg_c : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_score_digit_display_scanner.sv
// Directed bench for score_digit_display_scanner: 2-digit and 3-digit instances.
module tb_score_digit_display_scanner;
  import score_display_pkg::*;

  logic       CLK;
  logic       RESET;
  logic       sel;
  bcd_t       dat;
  logic [1:0] anode;
  logic [6:0] seg;
  logic       fv;
  logic [1:0] sel3;
  bcd_t       dat3;
  logic [2:0] anode3;
  logic [6:0] seg3;
  logic       fv3;

  int total = 0;
  int bad   = 0;

  score_digit_display_scanner #(
    .NUM_DIGITS(2), .SEL_W(1), .REFRESH_DIV(4), .BLANK_LZ(1'b1)
  ) dut (
    .CLK(CLK), .RESET(RESET), .STROBE_COUNTER(sel), .STROBED_SCORE(dat),
    .ANODE(anode), .SEG(seg), .FRAME_VALID(fv)
  );

  score_digit_display_scanner #(
    .NUM_DIGITS(3), .SEL_W(2), .REFRESH_DIV(4), .BLANK_LZ(1'b1)
  ) dut3 (
    .CLK(CLK), .RESET(RESET), .STROBE_COUNTER(sel3), .STROBED_SCORE(dat3),
    .ANODE(anode3), .SEG(seg3), .FRAME_VALID(fv3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bcd_t       d1;
    bcd_t       d0;
    logic [6:0] e1;
    logic [6:0] e0;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic s, input bcd_t d);
    @(negedge CLK);
    sel = s;
    dat = d;
  endtask

  task automatic strobe3(input logic [1:0] s, input bcd_t d);
    @(negedge CLK);
    sel3 = s;
    dat3 = d;
  endtask

  // Slot 0 then slot 1, then idle on slot 0 so no further commit happens.
  task automatic frame(input bcd_t d0, input bcd_t d1);
    strobe(1'b0, d0);
    strobe(1'b1, d1);
    strobe(1'b0, d0);
  endtask

  task automatic observe2(output logic [7:0] s0, output logic [7:0] s1, output int badan);
    s0 = 8'hFF;
    s1 = 8'hFF;
    badan = 0;
    @(negedge CLK);
    repeat (8) begin
      @(negedge CLK);
      case (anode)
        2'b10:   s0 = {1'b0, seg};
        2'b01:   s1 = {1'b0, seg};
        default: badan++;
      endcase
    end
  endtask

  task automatic observe3(output logic [7:0] s0, output logic [7:0] s1,
                          output logic [7:0] s2, output int badan);
    s0 = 8'hFF;
    s1 = 8'hFF;
    s2 = 8'hFF;
    badan = 0;
    repeat (12) begin
      @(negedge CLK);
      case (anode3)
        3'b110:  s0 = {1'b0, seg3};
        3'b101:  s1 = {1'b0, seg3};
        3'b011:  s2 = {1'b0, seg3};
        default: badan++;
      endcase
    end
  endtask

  initial begin
    logic [7:0] s0, s1, s2;
    int         badan;
    logic [1:0] prev;
    logic [1:0] nxt;
    int         run;
    int         nruns;
    int         seen;
    int         mixed;
    int         lit;

    vecs[0] = '{d1: 4'd3,  d0: 4'd7,  e1: 7'h30, e0: 7'h78};
    vecs[1] = '{d1: 4'd0,  d0: 4'd5,  e1: 7'h7F, e0: 7'h12};
    vecs[2] = '{d1: 4'd0,  d0: 4'd0,  e1: 7'h7F, e0: 7'h40};
    vecs[3] = '{d1: 4'd12, d0: 4'd0,  e1: 7'h3F, e0: 7'h40};
    vecs[4] = '{d1: 4'd9,  d0: 4'd8,  e1: 7'h10, e0: 7'h00};
    vecs[5] = '{d1: 4'd0,  d0: 4'd10, e1: 7'h7F, e0: 7'h3F};
    vecs[6] = '{d1: 4'd2,  d0: 4'd4,  e1: 7'h24, e0: 7'h19};
    vecs[7] = '{d1: 4'd1,  d0: 4'd6,  e1: 7'h79, e0: 7'h02};

    RESET = 1'b1;
    sel   = 1'b0;
    dat   = 4'd0;
    sel3  = 2'd3;
    dat3  = 4'd0;
    repeat (2) @(negedge CLK);
    chk("rst_anode", anode, 2'b11);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_fv", fv, 1'b0);
    chk("rst_anode3", anode3, 3'b111);
    RESET = 1'b0;

    // Three-digit instance: select 3 is out of range and must be ignored.
    strobe3(2'd0, 4'd1);
    strobe3(2'd1, 4'd2);
    strobe3(2'd3, 4'd9);
    strobe3(2'd3, 4'd9);
    chk("oor_no_commit", fv3, 1'b0);
    strobe3(2'd2, 4'd3);
    strobe3(2'd3, 4'd9);
    chk("oor_commit", fv3, 1'b1);
    observe3(s0, s1, s2, badan);
    chk("oor_slot0", s0, 8'h79);
    chk("oor_slot1", s1, 8'h24);
    chk("oor_slot2", s2, 8'h30);
    chk("oor_anode", badan, 0);

    // First frame: commit latency and per-digit hold time.
    strobe(1'b0, 4'd7);
    strobe(1'b1, 4'd3);
    chk("fv_before_last", fv, 1'b0);
    strobe(1'b0, 4'd7);
    chk("fv_after_last", fv, 1'b1);
    chk("dark_until_out_reg", anode, 2'b11);
    @(negedge CLK);
    prev  = anode;
    run   = 1;
    nruns = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (anode == prev) begin
        run++;
      end else begin
        if (nruns > 0) chk("hold_len", run, 4);
        nxt = ~prev;
        chk("anode_alt", anode, nxt);
        nruns++;
        prev = anode;
        run  = 1;
      end
    end
    chk("runs_seen", (nruns >= 4), 1'b1);

    for (int v = 0; v < 8; v++) begin
      frame(vecs[v].d0, vecs[v].d1);
      observe2(s0, s1, badan);
      chk($sformatf("vec%0d_slot0", v), s0, {1'b0, vecs[v].e0});
      chk($sformatf("vec%0d_slot1", v), s1, {1'b0, vecs[v].e1});
      chk($sformatf("vec%0d_anode", v), badan, 0);
    end

    // Repeated slot-0 writes alone never commit; last write wins once slot 1 arrives.
    strobe(1'b0, 4'd1);
    strobe(1'b0, 4'd2);
    strobe(1'b0, 4'd5);
    observe2(s0, s1, badan);
    chk("partial_slot0", s0, 8'h02);
    chk("partial_slot1", s1, 8'h79);
    strobe(1'b1, 4'd4);
    strobe(1'b0, 4'd5);
    observe2(s0, s1, badan);
    chk("lastwin_slot0", s0, 8'h12);
    chk("lastwin_slot1", s1, 8'h19);

    // Commit {9,9} over {1,2} at every refresh phase; no mixed frame may appear.
    for (int k = 0; k < 4; k++) begin
      frame(4'd2, 4'd1);
      repeat (8 + k) @(negedge CLK);
      sel   = 1'b0;
      dat   = 4'd9;
      seen  = 0;
      mixed = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge CLK);
        if (c == 0) sel = 1'b1;
        if (c == 1) sel = 1'b0;
        if (anode != 2'b11) begin
          if (seg == 7'h10) seen = 1;
          else if ((seg == 7'h79) || (seg == 7'h24)) begin
            if (seen != 0) mixed++;
          end else mixed++;
        end
      end
      chk($sformatf("atomic%0d_mixed", k), mixed, 0);
      chk($sformatf("atomic%0d_new", k), seen, 1);
    end

    // Asynchronous reset in the middle of a clock period.
    @(negedge CLK);
    chk("lit_before_reset", (anode != 2'b11), 1'b1);
    #2 RESET = 1'b1;
    #1;
    chk("async_anode", anode, 2'b11);
    chk("async_seg", seg, 7'h7F);
    chk("async_fv", fv, 1'b0);
    chk("async_fv3", fv3, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;

    // Partial frame straddling a reset is discarded.
    strobe(1'b0, 4'd4);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    sel = 1'b1;
    dat = 4'd6;
    lit = 0;
    repeat (10) begin
      @(negedge CLK);
      if (anode != 2'b11) lit++;
    end
    chk("midreset_fv", fv, 1'b0);
    chk("midreset_dark", lit, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
